// File: rtl/capsense_scanner.sv
// capsense_scanner: capacitive-touch front end for up to NUM_SENSE pads.
// Each scan discharges all pads, then releases them and counts cycles until
// each synchronised pad level reads high. The count is compared against a
// per-pad baseline captured on the first scan after reset. The result is
// debounced over DEBOUNCE agreeing scans.
//
// Ports:
//   clk       in   system clock
//   reset     in   asynchronous active-high reset
//   sense_in  in   raw pad levels (asynchronous)
//   sense_oe  out  1 = drive pad low, 0 = release to the external pull-up
//   touched   out  debounced touch state per pad
//   scan_done out  one-cycle pulse when touched/cal_done update
//   cal_done  out  baseline captured since the last reset
//
// Build option: define CAPSENSE_BASELINE_TRACK_EN to let untouched pads' baselines
// creep one count per scan toward the measured count (drift compensation).
// When it is undefined, the baseline is frozen at the calibration value.

module capsense_scanner #(
  parameter int unsigned NUM_SENSE        = 4,
  parameter int unsigned CNT_W            = 12,
  parameter int unsigned DISCHARGE_CYCLES = 256,
  parameter int unsigned TIMEOUT          = 4095,
  parameter int unsigned THRESHOLD        = 32,
  parameter int unsigned DEBOUNCE         = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_SENSE-1:0] sense_in,
  output logic [NUM_SENSE-1:0] sense_oe,
  output logic [NUM_SENSE-1:0] touched,
  output logic                 scan_done,
  output logic                 cal_done
);

  localparam int unsigned TcntMax = (DISCHARGE_CYCLES > TIMEOUT) ? DISCHARGE_CYCLES : TIMEOUT;
  localparam int unsigned TcntW   = $clog2(TcntMax + 1);

  localparam logic [TcntW-1:0] DischLast  = TcntW'(DISCHARGE_CYCLES - 1);
  localparam logic [TcntW-1:0] ChargeLast = TcntW'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CntSat     = CNT_W'(TIMEOUT);
  localparam logic [CNT_W:0]   ThreshExt  = (CNT_W + 1)'(THRESHOLD);
  localparam logic [2:0]       DbLast     = 3'(DEBOUNCE);

  typedef enum logic [1:0] {StDischarge, StCharge, StEval} state_e;

  state_e                          state_q, state_d;
  logic [TcntW-1:0]                tcnt_q, tcnt_d;
  logic [NUM_SENSE-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [NUM_SENSE-1:0][CNT_W-1:0] base_q, base_d;
  logic [NUM_SENSE-1:0][2:0]       db_q, db_d;
  logic [NUM_SENSE-1:0]            done_q, done_d;
  logic [NUM_SENSE-1:0]            touched_q, touched_d;
  logic                            cal_q, cal_d;
  logic                            scan_done_q;
  logic [NUM_SENSE-1:0]            sense_oe_q;
  logic [NUM_SENSE-1:0]            sync_q, s_in;
  logic [NUM_SENSE-1:0]            hit;

  // Two-flop synchroniser; its fixed lag ends up inside the baseline.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
      s_in   <= '0;
    end else begin
      sync_q <= sense_in;
      s_in   <= sync_q;
    end
  end

  always_comb begin
    state_d   = state_q;
    tcnt_d    = tcnt_q;
    cnt_d     = cnt_q;
    base_d    = base_q;
    db_d      = db_q;
    done_d    = done_q;
    touched_d = touched_q;
    cal_d     = cal_q;
    hit       = '0;

    case (state_q)
      StDischarge: begin
        if (tcnt_q == DischLast) begin
          state_d = StCharge;
          tcnt_d  = '0;
          cnt_d   = '0;
          done_d  = '0;
        end else begin
          tcnt_d = tcnt_q + TcntW'(1);
        end
      end

      StCharge: begin
        tcnt_d = tcnt_q + TcntW'(1);
        for (int i = 0; i < NUM_SENSE; i++) begin
          if (!done_q[i]) begin
            if (s_in[i]) begin
              done_d[i] = 1'b1;
            end else if (cnt_q[i] != CntSat) begin
              cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
          end
        end
        if ((&done_d) || (tcnt_q == ChargeLast)) begin
          state_d = StEval;
          tcnt_d  = '0;
        end
      end

      StEval: begin
        state_d = StDischarge;
        tcnt_d  = '0;
        for (int i = 0; i < NUM_SENSE; i++) begin
          // Extra bit keeps base + THRESHOLD from wrapping.
          hit[i] = {1'b0, cnt_q[i]} > ({1'b0, base_q[i]} + ThreshExt);
          if (!cal_q) begin
            base_d[i] = cnt_q[i];
          end else begin
            if (hit[i] == touched_q[i]) begin
              db_d[i] = '0;
            end else if (db_q[i] + 3'd1 == DbLast) begin
              touched_d[i] = hit[i];
              db_d[i]      = '0;
            end else begin
              db_d[i] = db_q[i] + 3'd1;
            end
`ifdef CAPSENSE_BASELINE_TRACK_EN
            if (!hit[i] && !touched_q[i]) begin
              if (cnt_q[i] > base_q[i]) begin
                base_d[i] = base_q[i] + CNT_W'(1);
              end else if (cnt_q[i] < base_q[i]) begin
                base_d[i] = base_q[i] - CNT_W'(1);
              end
            end
`endif
          end
        end
        cal_d = 1'b1;
      end

      default: state_d = StDischarge;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StDischarge;
      tcnt_q      <= '0;
      cnt_q       <= '0;
      base_q      <= '0;
      db_q        <= '0;
      done_q      <= '0;
      touched_q   <= '0;
      cal_q       <= 1'b0;
      scan_done_q <= 1'b0;
      sense_oe_q  <= '1;
    end else begin
      state_q     <= state_d;
      tcnt_q      <= tcnt_d;
      cnt_q       <= cnt_d;
      base_q      <= base_d;
      db_q        <= db_d;
      done_q      <= done_d;
      touched_q   <= touched_d;
      cal_q       <= cal_d;
      // Pulse lands in the cycle where touched/cal_done first show the new values.
      scan_done_q <= (state_q == StEval);
      // Registered from the next state so the pad drivers switch cleanly on the edge.
      sense_oe_q  <= {NUM_SENSE{state_d == StDischarge}};
    end
  end

  assign sense_oe  = sense_oe_q;
  assign touched   = touched_q;
  assign scan_done = scan_done_q;
  assign cal_done  = cal_q;

endmodule

// File: tb/tb_capsense_scanner.sv
module tb_capsense_scanner;

  localparam int NS      = 4;
  localparam int THR     = 32;
  localparam int DEB     = 3;
  localparam int NEVER   = 1000000;
  localparam int NTBL    = 19;
  localparam int MAXWAIT = 6000;

  logic          clk = 1'b0;
  logic          reset;
  logic [NS-1:0] sense_in;
  logic [NS-1:0] sense_oe;
  logic [NS-1:0] touched;
  logic          scan_done;
  logic          cal_done;

  always #5 clk = ~clk;

  capsense_scanner dut (
    .clk      (clk),
    .reset    (reset),
    .sense_in (sense_in),
    .sense_oe (sense_oe),
    .touched  (touched),
    .scan_done(scan_done),
    .cal_done (cal_done)
  );

  // Pad model: a released pad reads high once it has been released for dly cycles.
  int dly [NS];
  int rel [NS];

  always @(posedge clk) begin
    for (int i = 0; i < NS; i++) rel[i] <= sense_oe[i] ? 0 : rel[i] + 1;
  end

  always_comb begin
    sense_in = '0;
    for (int i = 0; i < NS; i++) sense_in[i] = !sense_oe[i] && (rel[i] >= dly[i]);
  end

  // Reference model in rise-delay units; the constant synchroniser offset cancels.
  int            m_base   [NS];
  int            m_streak [NS];
  logic [NS-1:0] m_touched;
  bit            m_cal;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int            d [NS];
    logic [NS-1:0] exp;
  } vec_t;

  vec_t tbl [NTBL];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void model_reset();
    m_cal     = 1'b0;
    m_touched = '0;
    for (int i = 0; i < NS; i++) begin
      m_base[i]   = 0;
      m_streak[i] = 0;
    end
  endfunction

  function automatic void model_scan();
    bit hit;
    bit old;
    if (!m_cal) begin
      for (int i = 0; i < NS; i++) m_base[i] = dly[i];
      m_cal = 1'b1;
    end else begin
      for (int i = 0; i < NS; i++) begin
        hit = dly[i] > m_base[i] + THR;
        old = m_touched[i];
        if (hit == old) begin
          m_streak[i] = 0;
        end else begin
          m_streak[i]++;
          if (m_streak[i] == DEB) begin
            m_touched[i] = hit;
            m_streak[i]  = 0;
          end
        end
`ifdef CAPSENSE_BASELINE_TRACK_EN
        if (!hit && !old) begin
          if (dly[i] > m_base[i]) m_base[i]++;
          else if (dly[i] < m_base[i]) m_base[i]--;
        end
`endif
      end
    end
  endfunction

  // Wait (bounded) for the next scan_done, advance the model, compare.
  task automatic scan(input string tag, output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!scan_done && cyc < MAXWAIT);
    check({tag, " scan_done seen"}, 32'(scan_done), 32'd1);
    if (scan_done) begin
      model_scan();
      check({tag, " touched"}, 32'(touched), 32'(m_touched));
      check({tag, " cal_done"}, 32'(cal_done), 32'(m_cal));
      check({tag, " sense_oe"}, 32'(sense_oe), 32'hf);
    end
  endtask

  task automatic set_all(input int v);
    for (int i = 0; i < NS; i++) dly[i] = v;
  endtask

  task automatic fill(input int k, input int a, input int b, input int c, input int e,
                      input logic [NS-1:0] x);
    tbl[k].d[0] = a;
    tbl[k].d[1] = b;
    tbl[k].d[2] = c;
    tbl[k].d[3] = e;
    tbl[k].exp  = x;
  endtask

  initial begin
    int cyc;

    for (int k = 0; k < 3; k++) fill(k, 100, 100, 140, 100, (k == 2) ? 4'b0100 : 4'b0000);
    for (int k = 3; k < 6; k++) fill(k, 100, 100, 100, 100, (k == 5) ? 4'b0000 : 4'b0100);
    for (int k = 6; k < 9; k++) fill(k, 100, 100, 100, 132, 4'b0000);
    for (int k = 9; k < 12; k++) fill(k, 100, 100, 100, 133, (k == 11) ? 4'b1000 : 4'b0000);
    for (int k = 12; k < 15; k++) fill(k, 100, 100, 100, 100, (k == 14) ? 4'b0000 : 4'b1000);
    fill(15, 100, 140, 100, 100, 4'b0000);
    fill(16, 100, 140, 100, 100, 4'b0000);
    fill(17, 100, 100, 100, 100, 4'b0000);
    fill(18, 100, 100, 100, 100, 4'b0000);

    // Reset state
    reset = 1'b1;
    set_all(100);
    model_reset();
    repeat (3) @(negedge clk);
    check("reset sense_oe", 32'(sense_oe), 32'hf);
    check("reset touched", 32'(touched), 32'h0);
    check("reset scan_done", 32'(scan_done), 32'h0);
    check("reset cal_done", 32'(cal_done), 32'h0);
    reset = 1'b0;

    // Calibration scan
    scan("cal", cyc);
    check("cal touched zero", 32'(touched), 32'h0);

    // Table: touch/debounce, threshold edge, debounce reject
    for (int k = 0; k < NTBL; k++) begin
      for (int i = 0; i < NS; i++) dly[i] = tbl[k].d[i];
      scan($sformatf("vec%0d", k), cyc);
`ifndef CAPSENSE_BASELINE_TRACK_EN
      check($sformatf("vec%0d table touched", k), 32'(touched), 32'(tbl[k].exp));
`endif
    end

    // Drift: pad 1 sits at 110, then 133 (touch only if baseline stayed at 100)
    dly[1] = 110;
    for (int k = 0; k < 11; k++) scan($sformatf("drift%0d", k), cyc);
    dly[1] = 133;
    for (int k = 0; k < 3; k++) scan($sformatf("drift_hi%0d", k), cyc);
    dly[1] = 100;
    for (int k = 0; k < 3; k++) scan($sformatf("drift_back%0d", k), cyc);

    // Reset in the middle of CHARGE, then recalibrate with pad 2 at 140
    repeat (300) @(negedge clk);
    check("midcharge released", 32'(sense_oe), 32'h0);
    reset = 1'b1;
    #1;
    check("midreset sense_oe", 32'(sense_oe), 32'hf);
    check("midreset cal_done", 32'(cal_done), 32'h0);
    check("midreset touched", 32'(touched), 32'h0);
    model_reset();
    dly[2] = 140;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    scan("recal", cyc);
    dly[2] = 100;
    for (int k = 0; k < 3; k++) scan($sformatf("postcal%0d", k), cyc);

    // Timeout: pad 0 never rises, pad 3 touched alongside
    dly[0] = NEVER;
    dly[3] = 140;
    scan("tmo0", cyc);
    check("timeout period", 32'(cyc), 32'd4352);
    scan("tmo1", cyc);
    scan("tmo2", cyc);
    check("timeout touched", 32'(touched), 32'b1001);
    set_all(100);
    for (int k = 0; k < 3; k++) scan($sformatf("tmo_clear%0d", k), cyc);
    check("timeout cleared", 32'(touched), 32'h0);

    // Randomised delays against the model
    for (int k = 0; k < 30; k++) begin
      for (int i = 0; i < NS; i++) dly[i] = 80 + int'($urandom_range(0, 100));
      scan($sformatf("rnd%0d", k), cyc);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/capsense_scanner.md
# capsense_scanner

Capacitive-touch front end for the Cramps board build, which has capacitive sensing enabled. The block measures RC charge time on up to `NUM_SENSE` pads, calibrates a per-pad baseline and debounces the result. It delivers clean `touched` bits to the hostmot2 input bits of the I/O port that carries the pads. It sits between the pad tristate buffers and the hostmot2 I/O port input mux.

## Interface
- `NUM_SENSE`, 4: number of pads, scanned in parallel.
- `CNT_W`, 12: charge-count width.
- `DISCHARGE_CYCLES`, 256: cycles each pad is driven low before a measurement.
- `TIMEOUT`, 4095: maximum charge cycles; must be ≤ 2^CNT_W−1.
- `THRESHOLD`, 32: count margin above baseline that means "touched".
- `DEBOUNCE`, 3: consecutive agreeing scans needed to change a `touched` bit; range 1..7.

Ports:
- `clk`  in  1: system clock, the hostmot2 `ClockLow` domain.
- `reset`  in  1: asynchronous, active-high.
- `sense_in`  in  NUM_SENSE: raw pad levels, asynchronous.
- `sense_oe`  out  NUM_SENSE: 1 = drive pad low; 0 = release so the external pull-up charges the pad. The pad output value is tied to 0 outside this block.
- `touched`  out  NUM_SENSE: debounced touch state per pad.
- `scan_done`  out  1: one-cycle pulse when `touched` and `cal_done` update.
- `cal_done`  out  1: set after the calibration scan completes.

## Operation
- Input path: 2-flop synchronizer on `sense_in`, giving `s_in`. The 2-cycle synchronizer lag is a constant offset that the baseline absorbs.
- The block has three states, `DISCHARGE`, `CHARGE` and `EVAL`, plus one global cycle counter `tcnt`.
- `DISCHARGE`:
  - `sense_oe` is all ones and `tcnt` increments.
  - When `tcnt == DISCHARGE_CYCLES-1`, go to `CHARGE`. On entry, clear `tcnt`, clear all `cnt[i]` and clear all `done[i]`.
- `CHARGE`:
  - `sense_oe` is all zeros and `tcnt` increments.
  - For each pad with `done[i]` = 0: if `s_in[i]` = 1, set `done[i]`; otherwise increment `cnt[i]`.
  - Exit to `EVAL` when all `done` bits are set or `tcnt == TIMEOUT-1`. On timeout, pads that never completed keep `cnt[i] = TIMEOUT`; counts saturate and never wrap.
- `EVAL` (exactly one cycle), then return to `DISCHARGE`:
  - First scan after reset (`cal_done` = 0): `base[i] <= cnt[i]`, set `cal_done`, leave `touched` at 0.
  - Later scans: `hit[i] = (cnt[i] > base[i] + THRESHOLD)`. The sum is computed at CNT_W+1 bits so it never overflows.
  - Debounce: if `hit[i]` equals `touched[i]`, clear `db[i]`. Otherwise increment `db[i]`; when it reaches `DEBOUNCE`, set `touched[i] <= hit[i]` and clear `db[i]`.
  - Assert `scan_done` for this one cycle.
- Pads are independent; a timed-out pad does not affect other pads' counts.

## Timing
- Reset values:
  - state `DISCHARGE`; `tcnt`, `cnt`, `done`, `db` and `base` all 0.
  - `sense_oe` all ones; `touched`, `scan_done` and `cal_done` all 0.
- Reset mid-scan aborts immediately: pads are driven low and the next measurement starts with a full discharge. Calibration repeats after every reset.
- Scan period = `DISCHARGE_CYCLES` + charge cycles + 1. The maximum is 256 + 4095 + 1 = 4352 cycles at defaults.
- `touched` and `cal_done` change on the clock edge that ends `EVAL`. They become visible in the same cycle that `scan_done` is high and stay stable until the next `EVAL`.
- Latency from a physical touch to `touched`: `DEBOUNCE` scans, plus up to one scan of alignment.
- `sense_oe` is registered and changes on the state-transition edge, with no glitches.

## Configuration
- `CAPSENSE_BASELINE_TRACK_EN` defined: in every post-calibration `EVAL`, for pads with `hit[i]` = 0 and `touched[i]` = 0:
  - `base[i]` moves 1 count toward `cnt[i]`: +1 if `cnt > base`, −1 if `cnt < base`, unchanged if equal.
  - This compensates for slow drift from humidity and temperature.
- Not defined: `base[i]` is frozen at the calibration value until the next reset.

## Test plan
- Calibration: pad model rises 100 cycles after release on all pads → first `scan_done` gives `cal_done` = 1, `base` = 100 on every pad, `touched` = 0.
- Touch with debounce (defaults): pad 2 rise delay changed to 140 → `touched[2]` = 1 at the 3rd following `scan_done`, other bits stay 0. Restoring the delay to 100 → `touched[2]` = 0 after 3 more scans.
- Threshold edge: delay 132 (cnt = 132 = base+32) → no touch; delay 133 → touch after 3 scans.
- Timeout: pad 0 never rises → `cnt[0]` saturates at 4095 and the scan lasts 256+4095+1 cycles; the other pads still evaluate correctly.
- Debounce reject: a 2-scan pulse of delay 140 on pad 1 → `touched[1]` stays 0 throughout.
- Reset mid-`CHARGE`: assert `reset` at cycle 300 → `sense_oe` all ones and `cal_done` = 0 in the same cycle; recalibration occurs on the next `scan_done`.
- Tracking (`CAPSENSE_BASELINE_TRACK_EN` builds only): delay ramped to 110 → `base` reaches 110 after 10 scans and no touch is reported. Without the macro → `touched` stays 0 and `base` stays 100.
